// File: rtl/uart_rx_core_pkg.sv
// uart_rx_core_pkg: shared definitions for the UART receive path (and the
// matching transmitter): receiver state encoding, frame width, default bit
// period, CSR bit positions, and the LSB-first shift helper.
package uart_rx_core_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 104;

  // Status register bit positions as seen by the CPU.
  localparam int UART_CSR_VALID_BIT     = 0;
  localparam int UART_CSR_FRAME_ERR_BIT = 1;
  localparam int UART_CSR_OVERRUN_BIT   = 2;

  typedef enum logic [2:0] {
    RX_RECOVER = 3'd0,
    RX_IDLE    = 3'd1,
    RX_START   = 3'd2,
    RX_DATA    = 3'd3,
    RX_STOP    = 3'd4
  } rx_state_e;

  // Serial data arrives LSB first: each new bit enters at the MSB end.
  function automatic logic [UART_DATA_BITS-1:0] shift_in_lsb_first(
    input logic [UART_DATA_BITS-1:0] cur,
    input logic                      bit_in
  );
    return {bit_in, cur[UART_DATA_BITS-1:1]};
  endfunction

endpackage

// File: rtl/uart_rx_core_fifo.sv
// uart_rx_fifo: small show-ahead FIFO for received bytes.
// Ports: clk/rst_n (async active-low), push/push_data write, pop read,
// full/empty status, head = oldest entry (registered, valid while !empty).
// A push into a full FIFO is accepted only when a pop happens in the same
// cycle (pop is applied first). DEPTH must be a power of two, >= 2.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             pop_ok_s, push_ok_s;

  // Next-state for pointers, storage and the registered head/flags.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pop_ok_s  = pop && !empty_q;
    push_ok_s = push && (!full_q || pop_ok_s);
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    // Head is pre-loaded from the next-state array so it is ready the cycle
    // after a push or pop; it holds its last value once empty.
    if (empty_d) begin
      head_d = head_q;
    end else begin
      head_d = mem_d[rd_ptr_d];
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = head_q;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: 8N1 UART receiver. Oversamples rx with CLK, checks start and
// stop bits, and stores received bytes for the CPU register interface.
// Ports: CLK, resetn (async active-low), rx (async serial, idle high),
// rd_en (pop head byte), clr_err (clear sticky flags); data (head byte),
// valid (byte held), frame_err (sticky, bad stop bit), overrun (sticky,
// byte lost because storage was full).
// Build option: define UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO instead
// of the single holding register.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      CLK,
  input  logic                      resetn,
  input  logic                      rx,
  input  logic                      rd_en,
  input  logic                      clr_err,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  output logic                      frame_err,
  output logic                      overrun
);

  localparam int TICK_W = $clog2(CLKS_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(CLKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_MID   = TICK_W'(CLKS_PER_BIT / 2 - 1);
  // Cycles RECOVER waits so the reset value of the synchroniser has flushed.
  localparam logic [TICK_W-1:0] TICK_FLUSH = TICK_W'(2);
  localparam logic [2:0]        LAST_BIT   = 3'(UART_DATA_BITS - 1);

  logic                      rx_meta_q, rx_s_q;
  rx_state_e                 state_q, state_d;
  logic [TICK_W-1:0]         tick_q, tick_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      push_s, stop_err_s, pop_s, store_full_s;
  logic                      frame_err_q, frame_err_d, overrun_q, overrun_d;

  // Two-flop synchroniser on the asynchronous line; resets to idle-high.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver next-state: bit timing, sampling and push/error strobes.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_s     = 1'b0;
    stop_err_s = 1'b0;
    case (state_q)
      RX_RECOVER: begin
        // The synchroniser comes out of reset high, so the line is only
        // trusted after it has been refilled from rx.
        if (tick_q != TICK_FLUSH) begin
          tick_d = tick_q + TICK_W'(1);
        end else if (rx_s_q) begin
          state_d = RX_IDLE;
          tick_d  = '0;
        end else begin
          state_d = RX_RECOVER;
        end
      end
      RX_IDLE: begin
        tick_d = '0;
        if (!rx_s_q) begin
          state_d = RX_START;
        end else begin
          state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (tick_q == TICK_MID) begin
          tick_d    = '0;
          bit_cnt_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          if (rx_s_q) begin
            state_d = RX_IDLE;
          end else begin
            state_d = RX_DATA;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      RX_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = shift_in_lsb_first(shift_q, rx_s_q);
          if (bit_cnt_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      RX_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s_q) begin
            push_s  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            // Break or noise: drop the byte and wait for the line to idle.
            stop_err_s = 1'b1;
            state_d    = RX_RECOVER;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: begin
        state_d = RX_RECOVER;
        tick_d  = '0;
      end
    endcase
  end

  // Receiver FSM registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RX_RECOVER;
      tick_q    <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Sticky error flags: a new error in the clearing cycle keeps the flag set.
  always_comb begin
    if (stop_err_s) begin
      frame_err_d = 1'b1;
    end else if (clr_err) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
    if (push_s && store_full_s && !pop_s) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Error flag registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

`ifdef UART_RX_FIFO_EN
  logic fifo_full_s, fifo_empty_s;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (resetn),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (shift_q),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (data)
  );

  assign valid        = !fifo_empty_s;
  assign pop_s        = rd_en && !fifo_empty_s;
  assign store_full_s = fifo_full_s;
`else
  logic [UART_DATA_BITS-1:0] data_q, data_d;
  logic                      valid_q, valid_d;

  // Holding register: pop is applied before push, so a read in the push
  // cycle frees the slot for the new byte.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (push_s && (!valid_q || pop_s)) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (pop_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register flops.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data         = data_q;
  assign valid        = valid_q;
  assign pop_s        = rd_en && valid_q;
  assign store_full_s = valid_q;

  // FIFO_DEPTH only sizes the optional FIFO; referenced here to keep it bound.
  if (FIFO_DEPTH < 2) begin : g_fifo_depth_unused
  end
`endif

endmodule
